cpu_control: RTL
================

Name: cpu_control

Overview:
- Multi-cycle instruction sequencer sitting directly upstream of the Mini-CPU 16x16 register bank.
- Accepts one instruction at a time through a valid/ready handshake.
- Drives the bank's read address and write port (dest, data, we), and reads operands back through the bank's registered-address read.
- Computes the result with an internal ALU, writes it back, and reports completion, result and flags.

Parameters:
- DATA_W, 16, register/data width; must match the register bank.
- ADDR_W, 4, register index width (16 registers).
- INSTR_W, 3+3*ADDR_W (15), instruction width; derived, not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- instr  in  INSTR_W  instruction: [14:12] opcode, [11:8] dest, [7:4] src1, [3:0] src2; for LOAD, [7:0] is imm8.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  high only in IDLE; accept when instr_valid && instr_ready at a rising edge.
- mem_raddr  out  ADDR_W  register bank read address (bank registers it; data valid next cycle).
- mem_rdata  in  DATA_W  register bank read data.
- mem_waddr  out  ADDR_W  register bank write address (dest).
- mem_wdata  out  DATA_W  register bank write data.
- mem_we  out  1  register bank write enable.
- result  out  DATA_W  last computed result, held until next EXEC.
- flag_z, flag_n, flag_v  out  1  zero, negative (result[15]), signed overflow; updated with result.
- done  out  1  one-cycle pulse on instruction completion.

Behaviour:
- Opcodes:
  - 000 LOAD: dest <= sext(imm8).
  - 001 ADD.
  - 010 SUB (src1-src2).
  - 011 AND.
  - 100 OR.
  - 101 XOR.
  - 110 SLT: signed src1<src2 gives 16'h0001, else 16'h0000.
  - 111 DISP: read src1 into result; no write.
- Arithmetic wraps modulo 2^16.
- flag_v is set only for ADD/SUB signed overflow; it is 0 for all other ops.
- States: IDLE, RD_A, RD_B, EXEC, WB, DONE. Encoding lives in the package.
- Transitions:
  - IDLE -> RD_A on accept; for LOAD, IDLE -> EXEC.
  - RD_A -> RD_B -> EXEC.
  - EXEC -> WB for opcodes 000-110; EXEC -> DONE for DISP.
  - WB -> DONE -> IDLE.
- Instruction fields are latched at the accept edge. instr and instr_valid are ignored outside IDLE.
- RD_A: mem_raddr=src1.
- RD_B: mem_raddr=src2; opA latched from mem_rdata at the exit edge.
- EXEC: operand B is mem_rdata (ram[src2]). result and flags are registered at the exit edge.
- DISP: result=opA.
- WB: mem_we=1, mem_waddr=dest, mem_wdata=result.
- mem_we is 0 in every other state. mem_raddr defaults to src1; mem_waddr/mem_wdata hold their last values.
- done=1 only in the DONE state. instr_ready rises again in the cycle after DONE.
- Latency from the accept edge to the edge that enters DONE:
  - ALU ops: 4 cycles.
  - LOAD: 2 cycles.
  - DISP: 3 cycles.
- Throughput: one instruction per 6 cycles (ALU ops). No overlap between instructions.
- src1==src2 and dest==src are legal. Reads always complete before the write, so no hazard exists.
- Reset values: state IDLE, instr_ready=1, mem_we=0, done=0, result=0, flags=0, mem_raddr/mem_waddr/mem_wdata=0.
- Reset mid-operation aborts immediately. mem_we drops asynchronously, so an in-flight WB performs no write. Register bank contents are not touched by reset.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams OP_LOAD..OP_DISP;
  - state encoding;
  - instruction field bit positions;
  - DATA_W/ADDR_W defaults.
- One combinational sub-module, cpu_alu:
  - inputs: opcode, a, b, imm8;
  - outputs: y, z, n, v.
- cpu_control instantiates cpu_alu and contains the FSM, operand/result registers and handshake.

Test Plan:
- LOAD r3, imm8=8'hF6 -> mem_we=1 with waddr=3, wdata=16'hFFF6 exactly one cycle; done 3 cycles after accept; result=FFF6, flag_n=1.
- Preload r1=16'h7FFF, r2=16'h0001; ADD r4,r1,r2 -> write r4=16'h8000; flag_v=1, flag_n=1, flag_z=0; done 5 cycles after accept.
- Preload r5=16'hFFFF, r6=16'h0001:
  - SLT r7,r5,r6 -> r7=16'h0001.
  - SUB r7,r6,r6 -> r7=0, flag_z=1.
- DISP r1 (r1=16'h1234) -> result=16'h1234, mem_we never asserted; done 4 cycles after accept.
- Hold instr_valid high with back-to-back ADDs -> instr_ready low from accept through DONE; the second instruction is accepted only after DONE; the first instruction's fields are not overwritten.
- Assert rst_n low during WB of an ADD -> mem_we falls immediately and the target register keeps its old value; after release, instr_ready=1, result=0, done=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the Mini-CPU sequencer: opcodes, FSM states and instruction layout.
package cpu_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned ADDR_W_DEF = 4;
    localparam int unsigned OPC_W      = 3;
    localparam int unsigned IMM_W      = 8;

    // Register fields sit in ADDR_W-wide slots above bit 0; the opcode sits above slot 2.
    localparam int unsigned SRC2_SLOT = 0;
    localparam int unsigned SRC1_SLOT = 1;
    localparam int unsigned DST_SLOT  = 2;
    localparam int unsigned OPC_SLOT  = 3;

    localparam logic [OPC_W-1:0] OP_LOAD = 3'b000;
    localparam logic [OPC_W-1:0] OP_ADD  = 3'b001;
    localparam logic [OPC_W-1:0] OP_SUB  = 3'b010;
    localparam logic [OPC_W-1:0] OP_AND  = 3'b011;
    localparam logic [OPC_W-1:0] OP_OR   = 3'b100;
    localparam logic [OPC_W-1:0] OP_XOR  = 3'b101;
    localparam logic [OPC_W-1:0] OP_SLT  = 3'b110;
    localparam logic [OPC_W-1:0] OP_DISP = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_EXEC,
        S_WB,
        S_DONE
    } state_t;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for the sequencer; V is only meaningful for ADD/SUB.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic [OPC_W-1:0]  opcode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [IMM_W-1:0]  imm8,
    output logic [DATA_W-1:0] y,
    output logic              z,
    output logic              n,
    output logic              v
);

    localparam int unsigned MSB = DATA_W - 1;

    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_diff;

    assign w_sum  = a + b;
    assign w_diff = a - b;

    always_comb begin
        y = '0;
        v = 1'b0;
        case (opcode)
            OP_LOAD: y = {{(DATA_W-IMM_W){imm8[IMM_W-1]}}, imm8};
            OP_ADD: begin
                y = w_sum;
                v = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                y = w_diff;
                v = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);
            end
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_SLT:  y = ($signed(a) < $signed(b)) ? {{(DATA_W-1){1'b0}}, 1'b1} : '0;
            OP_DISP: y = a;
            default: y = '0;
        endcase
    end

    assign z = (y == '0);
    assign n = y[MSB];

endmodule

// File: rtl/cpu_control.sv
// Multi-cycle instruction sequencer driving the 16x16 register bank through a registered-address read port.
module cpu_control
    import cpu_pkg::*;
#(
    parameter  int unsigned DATA_W  = DATA_W_DEF,
    parameter  int unsigned ADDR_W  = ADDR_W_DEF,
    localparam int unsigned INSTR_W = OPC_W + 3 * ADDR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    output logic [ADDR_W-1:0]  mem_raddr,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic [ADDR_W-1:0]  mem_waddr,
    output logic [DATA_W-1:0]  mem_wdata,
    output logic               mem_we,
    output logic [DATA_W-1:0]  result,
    output logic               flag_z,
    output logic               flag_n,
    output logic               flag_v,
    output logic               done
);

    state_t r_state;

    logic [OPC_W-1:0]  r_op;
    logic [ADDR_W-1:0] r_dst;
    logic [ADDR_W-1:0] r_src1;
    logic [ADDR_W-1:0] r_src2;
    logic [IMM_W-1:0]  r_imm8;
    logic [DATA_W-1:0] r_opa;

    logic              r_ready;
    logic [ADDR_W-1:0] r_raddr;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_we;
    logic [DATA_W-1:0] r_result;
    logic              r_z;
    logic              r_n;
    logic              r_v;
    logic              r_done;

    logic [OPC_W-1:0]  w_opc_in;
    logic [ADDR_W-1:0] w_dst_in;
    logic [ADDR_W-1:0] w_src1_in;
    logic [ADDR_W-1:0] w_src2_in;
    logic [IMM_W-1:0]  w_imm8_in;

    logic [DATA_W-1:0] w_y;
    logic              w_z;
    logic              w_n;
    logic              w_v;

    assign w_opc_in  = instr[OPC_SLOT*ADDR_W  +: OPC_W];
    assign w_dst_in  = instr[DST_SLOT*ADDR_W  +: ADDR_W];
    assign w_src1_in = instr[SRC1_SLOT*ADDR_W +: ADDR_W];
    assign w_src2_in = instr[SRC2_SLOT*ADDR_W +: ADDR_W];
    assign w_imm8_in = instr[IMM_W-1:0];

    // Operand B comes straight from the bank: during EXEC it holds ram[src2].
    cpu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .opcode (r_op),
        .a      (r_opa),
        .b      (mem_rdata),
        .imm8   (r_imm8),
        .y      (w_y),
        .z      (w_z),
        .n      (w_n),
        .v      (w_v)
    );

    // The read address is registered one state ahead because the bank registers it again internally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_op     <= OP_LOAD;
            r_dst    <= '0;
            r_src1   <= '0;
            r_src2   <= '0;
            r_imm8   <= '0;
            r_opa    <= '0;
            r_ready  <= 1'b1;
            r_raddr  <= '0;
            r_waddr  <= '0;
            r_wdata  <= '0;
            r_we     <= 1'b0;
            r_result <= '0;
            r_z      <= 1'b0;
            r_n      <= 1'b0;
            r_v      <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (instr_valid) begin
                        r_op    <= w_opc_in;
                        r_dst   <= w_dst_in;
                        r_src1  <= w_src1_in;
                        r_src2  <= w_src2_in;
                        r_imm8  <= w_imm8_in;
                        r_raddr <= w_src1_in;
                        r_ready <= 1'b0;
                        r_state <= (w_opc_in == OP_LOAD) ? S_EXEC : S_RD_A;
                    end
                end
                S_RD_A: begin
                    r_raddr <= r_src2;
                    r_state <= S_RD_B;
                end
                S_RD_B: begin
                    r_opa   <= mem_rdata;
                    r_raddr <= r_src1;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_result <= w_y;
                    r_z      <= w_z;
                    r_n      <= w_n;
                    r_v      <= w_v;
                    if (r_op == OP_DISP) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_we    <= 1'b1;
                        r_waddr <= r_dst;
                        r_wdata <= w_y;
                        r_state <= S_WB;
                    end
                end
                S_WB: begin
                    r_we    <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_we    <= 1'b0;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign instr_ready = r_ready;
    assign mem_raddr   = r_raddr;
    assign mem_waddr   = r_waddr;
    assign mem_wdata   = r_wdata;
    assign mem_we      = r_we;
    assign result      = r_result;
    assign flag_z      = r_z;
    assign flag_n      = r_n;
    assign flag_v      = r_v;
    assign done        = r_done;

endmodule
